// File: rtl/ram_dp_scrub_pkg.sv
// Shared types and helpers for the scrubbed dual-port RAM.
//   state_e         : scrub FSM states
//   RDW_*           : read-during-write selector values for WRITE_FIRST
//   lat_legal()     : true for a supported read latency
package ram_dp_scrub_pkg;

   typedef enum logic {
      StScrub,
      StRun
   } state_e;

   localparam int unsigned RDW_READ_FIRST  = 0;
   localparam int unsigned RDW_WRITE_FIRST = 1;

   function automatic logic lat_legal(int unsigned lat);
      return (lat == 1) || (lat == 2);
   endfunction

endpackage

// File: rtl/ram_dp_scrub_if.sv
// Bus bundle for ram_dp_scrub: two access ports, scrub request and status.
//   master : requester side (drives en/wr/addr/din and clr_req)
//   slave  : RAM side (drives dout/vld, ready and collision)
interface ram_dp_scrub_if #(
   parameter int unsigned DATA = 198,
   parameter int unsigned ADDR = 6
);
   logic            clr_req;
   logic            ready;
   logic            collision;

   logic            a_en;
   logic            a_wr;
   logic [ADDR-1:0] a_addr;
   logic [DATA-1:0] a_din;
   logic [DATA-1:0] a_dout;
   logic            a_vld;

   logic            b_en;
   logic            b_wr;
   logic [ADDR-1:0] b_addr;
   logic [DATA-1:0] b_din;
   logic [DATA-1:0] b_dout;
   logic            b_vld;

   modport master (
      output clr_req, a_en, a_wr, a_addr, a_din, b_en, b_wr, b_addr, b_din,
      input  ready, collision, a_dout, a_vld, b_dout, b_vld
   );

   modport slave (
      input  clr_req, a_en, a_wr, a_addr, a_din, b_en, b_wr, b_addr, b_din,
      output ready, collision, a_dout, a_vld, b_dout, b_vld
   );
endinterface

// File: rtl/ram_dp_scrub_out_pipe.sv
// Per-port read-data delay line: 1 or 2 register stages.
//   clk, reset_n : clock, synchronous active-low reset (clears data and valid)
//   in_vld       : access accepted on this edge
//   in_data      : data to return for that access
//   dout, vld    : delayed data (holds when idle) and one-cycle valid
module ram_dp_scrub_out_pipe #(
   parameter int unsigned DATA     = 198,
   parameter int unsigned READ_LAT = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_vld,
   input  logic [DATA-1:0] in_data,
   output logic [DATA-1:0] dout,
   output logic            vld
);

   logic [DATA-1:0] s1_data_q;
   logic            s1_vld_q;

   // Data registers load only on a valid access so dout holds between accesses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_data_q <= '0;
         s1_vld_q  <= 1'b0;
      end else begin
         s1_vld_q <= in_vld;
         if (in_vld) s1_data_q <= in_data;
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic [DATA-1:0] s2_data_q;
         logic            s2_vld_q;

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               s2_data_q <= '0;
               s2_vld_q  <= 1'b0;
            end else begin
               s2_vld_q <= s1_vld_q;
               if (s1_vld_q) s2_data_q <= s1_data_q;
            end
         end

         assign dout = s2_data_q;
         assign vld  = s2_vld_q;
      end else begin : g_lat1
         assign dout = s1_data_q;
         assign vld  = s1_vld_q;
      end
   endgenerate

endmodule

// File: rtl/ram_dp_scrub.sv
// True dual-port RAM with hardware zero-scrub after reset or on clr_req.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : port A/B en/wr/addr/din -> dout/vld, clr_req -> ready, collision
// Same-address double write: A is stored, B is discarded, collision pulses with a_vld.
// Cross-port read of an address being written returns the old contents.
module ram_dp_scrub
   import ram_dp_scrub_pkg::*;
#(
   parameter int unsigned DATA        = 198,
   parameter int unsigned ADDR        = 6,
   parameter int unsigned READ_LAT    = 1,
   parameter int unsigned WRITE_FIRST = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   ram_dp_scrub_if.slave bus
);

   localparam int unsigned DEPTH = 2 ** ADDR;
   localparam logic        WF    = (WRITE_FIRST == RDW_WRITE_FIRST);

   generate
      if (!lat_legal(READ_LAT)) begin : g_bad_lat
         $error("ram_dp_scrub: READ_LAT must be 1 or 2");
      end
   endgenerate

   logic [DATA-1:0] mem [DEPTH];

   state_e          state_q;
   logic [ADDR-1:0] ptr_q;
   logic            ready_q;

   // Scrub FSM; ready is registered alongside the state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StScrub;
         ptr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            StScrub: begin
               ptr_q <= ptr_q + ADDR'(1);
               if (&ptr_q) begin
                  state_q <= StRun;
                  ready_q <= 1'b1;
               end
            end
            StRun: begin
               if (bus.clr_req) begin
                  state_q <= StScrub;
                  ptr_q   <= '0;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= StScrub;
               ptr_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   logic a_acc, b_acc, a_we, b_wr_req, same_addr, coll, b_we;

   assign a_acc     = reset_n & ready_q & bus.a_en;
   assign b_acc     = reset_n & ready_q & bus.b_en;
   assign a_we      = a_acc & bus.a_wr;
   assign b_wr_req  = b_acc & bus.b_wr;
   assign same_addr = (bus.a_addr == bus.b_addr);
   assign coll      = a_we & b_wr_req & same_addr;
   // Port A wins a same-address double write.
   assign b_we      = b_wr_req & ~coll;

   // Scrub shares port A's write path; ports are idle while scrubbing.
   logic            scrub;
   logic            wa_en;
   logic [ADDR-1:0] wa_addr;
   logic [DATA-1:0] wa_data;

   assign scrub = reset_n & (state_q == StScrub);

   always_comb begin
      wa_en   = a_we;
      wa_addr = bus.a_addr;
      wa_data = bus.a_din;
      if (scrub) begin
         wa_en   = 1'b1;
         wa_addr = ptr_q;
         wa_data = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (wa_en) mem[wa_addr] <= wa_data;
      if (b_we)  mem[bus.b_addr] <= bus.b_din;
   end

   // Reads see pre-write contents; the own-port write data substitutes when WF.
   logic [DATA-1:0] a_rd, b_rd;

   always_comb begin
      a_rd = mem[bus.a_addr];
      b_rd = mem[bus.b_addr];
      if (WF && bus.a_wr) a_rd = bus.a_din;
      if (WF && bus.b_wr) b_rd = bus.b_din;
   end

   // Collision rides in the top bit of port A's pipe so it stays aligned with a_vld.
   logic [DATA:0] a_pipe_dout;
   logic          a_pipe_vld;

   ram_dp_scrub_out_pipe #(
      .DATA     (DATA + 1),
      .READ_LAT (READ_LAT)
   ) u_pipe_a (
      .clk     (clk),
      .reset_n (reset_n),
      .in_vld  (a_acc),
      .in_data ({coll, a_rd}),
      .dout    (a_pipe_dout),
      .vld     (a_pipe_vld)
   );

   ram_dp_scrub_out_pipe #(
      .DATA     (DATA),
      .READ_LAT (READ_LAT)
   ) u_pipe_b (
      .clk     (clk),
      .reset_n (reset_n),
      .in_vld  (b_acc),
      .in_data (b_rd),
      .dout    (bus.b_dout),
      .vld     (bus.b_vld)
   );

   assign bus.a_dout    = a_pipe_dout[DATA-1:0];
   assign bus.a_vld     = a_pipe_vld;
   assign bus.collision = a_pipe_vld & a_pipe_dout[DATA];
   assign bus.ready     = ready_q;

endmodule

// File: tb/tb_ram_dp_scrub.sv
// Scoreboard bench: two instances (lat1/write-first and lat2/read-first) share stimulus.
module tb_ram_dp_scrub;

   localparam int unsigned DATA  = 16;
   localparam int unsigned ADDR  = 4;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   ram_dp_scrub_if #(.DATA(DATA), .ADDR(ADDR)) bus0 ();
   ram_dp_scrub_if #(.DATA(DATA), .ADDR(ADDR)) bus1 ();

   ram_dp_scrub #(.DATA(DATA), .ADDR(ADDR), .READ_LAT(1), .WRITE_FIRST(1)) u_dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus0.slave)
   );

   ram_dp_scrub #(.DATA(DATA), .ADDR(ADDR), .READ_LAT(2), .WRITE_FIRST(0)) u_dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus1.slave)
   );

   typedef struct {
      logic            en;
      logic            wr;
      logic [ADDR-1:0] addr;
      logic [DATA-1:0] din;
   } op_t;

   typedef struct {
      logic [DATA-1:0] data;
      logic            coll;
      int unsigned     cyc;
   } exp_t;

   // Queue index: 0 dut0.A, 1 dut0.B, 2 dut1.A, 3 dut1.B
   exp_t            sb [4][$];
   logic [DATA-1:0] last [4];
   logic [DATA-1:0] mem_m [DEPTH];
   logic            m_ready;
   int unsigned     m_ptr;
   int unsigned     cyc;
   int              errors;
   int              checks;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic op_t nop();
      op_t o;
      o.en = 1'b0; o.wr = 1'b0; o.addr = '0; o.din = '0;
      return o;
   endfunction

   function automatic op_t rd(input int unsigned addr);
      op_t o;
      o.en = 1'b1; o.wr = 1'b0; o.addr = ADDR'(addr); o.din = '0;
      return o;
   endfunction

   function automatic op_t wr(input int unsigned addr, input logic [DATA-1:0] d);
      op_t o;
      o.en = 1'b1; o.wr = 1'b1; o.addr = ADDR'(addr); o.din = d;
      return o;
   endfunction

   task automatic zero_model();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
   endtask

   task automatic check_port(input int k, input logic vld, input logic [DATA-1:0] dout,
                             input logic coll, input string name);
      exp_t e;
      if (vld) begin
         if (sb[k].size() == 0) begin
            check({name, "_spurious_vld"}, vld, 1'b0);
         end else begin
            e = sb[k].pop_front();
            check({name, "_latency"}, cyc, e.cyc);
            check({name, "_dout"}, dout, e.data);
            if (k % 2 == 0) check({name, "_collision"}, coll, e.coll);
            last[k] = e.data;
         end
      end else begin
         check({name, "_hold"}, dout, last[k]);
         if (k % 2 == 0) check({name, "_collision_idle"}, coll, 1'b0);
         if (sb[k].size() != 0 && sb[k][0].cyc <= cyc) begin
            check({name, "_missing_vld"}, vld, 1'b1);
            void'(sb[k].pop_front());
         end
      end
   endtask

   // One clock: drive, predict, clock, advance the model, compare.
   task automatic step(input op_t a, input op_t b, input logic clr, input logic rst_v);
      exp_t e;
      logic acc_a, acc_b, col;
      reset_n      = rst_v;
      bus0.clr_req = clr;    bus1.clr_req = clr;
      bus0.a_en    = a.en;   bus1.a_en    = a.en;
      bus0.a_wr    = a.wr;   bus1.a_wr    = a.wr;
      bus0.a_addr  = a.addr; bus1.a_addr  = a.addr;
      bus0.a_din   = a.din;  bus1.a_din   = a.din;
      bus0.b_en    = b.en;   bus1.b_en    = b.en;
      bus0.b_wr    = b.wr;   bus1.b_wr    = b.wr;
      bus0.b_addr  = b.addr; bus1.b_addr  = b.addr;
      bus0.b_din   = b.din;  bus1.b_din   = b.din;

      acc_a = rst_v && m_ready && a.en;
      acc_b = rst_v && m_ready && b.en;
      col   = acc_a && acc_b && a.wr && b.wr && (a.addr == b.addr);
      if (acc_a) begin
         e.coll = col;
         e.data = a.wr ? a.din : mem_m[a.addr]; e.cyc = cyc + 1; sb[0].push_back(e);
         e.data = mem_m[a.addr];                e.cyc = cyc + 2; sb[2].push_back(e);
      end
      if (acc_b) begin
         e.coll = 1'b0;
         e.data = b.wr ? b.din : mem_m[b.addr]; e.cyc = cyc + 1; sb[1].push_back(e);
         e.data = mem_m[b.addr];                e.cyc = cyc + 2; sb[3].push_back(e);
      end
      if (acc_b && b.wr && !col) mem_m[b.addr] = b.din;
      if (acc_a && a.wr) mem_m[a.addr] = a.din;

      @(posedge clk);
      #1;
      cyc++;

      if (!rst_v) begin
         m_ready = 1'b0;
         m_ptr   = 0;
         zero_model();
         for (int k = 0; k < 4; k++) begin
            sb[k].delete();
            last[k] = '0;
         end
      end else if (!m_ready) begin
         if (m_ptr == DEPTH - 1) begin
            m_ready = 1'b1;
            m_ptr   = 0;
         end else begin
            m_ptr++;
         end
      end else if (clr) begin
         m_ready = 1'b0;
         m_ptr   = 0;
         zero_model();
      end

      check("d0_ready", bus0.ready, m_ready);
      check("d1_ready", bus1.ready, m_ready);
      check_port(0, bus0.a_vld, bus0.a_dout, bus0.collision, "d0_a");
      check_port(1, bus0.b_vld, bus0.b_dout, 1'b0, "d0_b");
      check_port(2, bus1.a_vld, bus1.a_dout, bus1.collision, "d1_a");
      check_port(3, bus1.b_vld, bus1.b_dout, 1'b0, "d1_b");
   endtask

   // Steps until ready rises (bounded); returns the number of low cycles.
   task automatic wait_ready(input logic poke, output int unsigned lowc);
      lowc = 0;
      while (lowc < 40) begin
         if (poke) step(wr(lowc % DEPTH, 16'hDEAD), rd(lowc % DEPTH), (lowc == 5), 1'b1);
         else      step(nop(), nop(), 1'b0, 1'b1);
         lowc++;
         if (bus0.ready) break;
      end
   endtask

   initial begin
      int unsigned lowc;
      errors  = 0;
      checks  = 0;
      cyc     = 0;
      m_ready = 1'b0;
      m_ptr   = 0;
      zero_model();
      for (int k = 0; k < 4; k++) last[k] = '0;

      step(nop(), nop(), 1'b0, 1'b0);
      step(nop(), nop(), 1'b0, 1'b0);

      // Scrub after reset, with dropped accesses and an ignored clr_req.
      wait_ready(1'b1, lowc);
      check("scrub_len_reset", lowc, 16);
      for (int i = 0; i < DEPTH; i++) step(rd(i), rd(DEPTH - 1 - i), 1'b0, 1'b1);

      step(wr(3, 16'h01F5), nop(), 1'b0, 1'b1);
      step(rd(3), nop(), 1'b0, 1'b1);
      step(wr(7, 16'h00AA), rd(7), 1'b0, 1'b1);
      step(nop(), rd(7), 1'b0, 1'b1);
      step(wr(5, 16'h0011), wr(5, 16'h0022), 1'b0, 1'b1);
      step(rd(5), rd(5), 1'b0, 1'b1);
      step(wr(9, 16'h0003), nop(), 1'b0, 1'b1);
      step(wr(9, 16'h0004), nop(), 1'b0, 1'b1);
      step(rd(9), rd(9), 1'b0, 1'b1);

      // Back-to-back mixed traffic including occasional collisions.
      for (int i = 0; i < 60; i++) begin
         op_t a, b;
         a.en = 1'($urandom_range(0, 3) != 0); a.wr = 1'($urandom_range(0, 1));
         a.addr = ADDR'($urandom_range(0, 3)); a.din = DATA'($urandom);
         b.en = 1'($urandom_range(0, 3) != 0); b.wr = 1'($urandom_range(0, 1));
         b.addr = ADDR'($urandom_range(0, 3)); b.din = DATA'($urandom);
         step(a, b, 1'b0, 1'b1);
      end

      // Fill, then rescrub on request; the request-cycle access still completes.
      for (int i = 0; i < DEPTH; i++) step(wr(i, DATA'(16'h5A00 + i)), nop(), 1'b0, 1'b1);
      step(rd(2), wr(4, 16'h7777), 1'b1, 1'b1);
      wait_ready(1'b0, lowc);
      check("scrub_len_clr", lowc, 16);
      for (int i = 0; i < DEPTH; i++) step(rd(i), rd(i), 1'b0, 1'b1);

      // Reset part-way through a scrub restarts it from the beginning.
      step(wr(1, 16'h1234), nop(), 1'b0, 1'b1);
      step(nop(), nop(), 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) step(nop(), nop(), 1'b0, 1'b1);
      step(nop(), nop(), 1'b0, 1'b0);
      wait_ready(1'b0, lowc);
      check("scrub_len_midreset", lowc, 16);
      step(rd(1), rd(0), 1'b0, 1'b1);

      for (int i = 0; i < 4; i++) step(nop(), nop(), 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) check($sformatf("drain_%0d", k), sb[k].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
